// File: rtl/seq_pourer.sv
// Serialises a length descriptor plus packed 2-bit-per-base words into one {valid, base} symbol
// per cycle with pouring framing; optional SEQ_POURER_CNT_EN adds a per-sequence symbol counter.
module seq_pourer #(
  parameter int unsigned WORD_BASES = 16,
  parameter int unsigned LEN_BITS   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    seq_valid_i,
  input  logic [LEN_BITS-1:0]     seq_len_i,
  output logic                    seq_ready_o,
  input  logic                    word_valid_i,
  input  logic [2*WORD_BASES-1:0] word_i,
  output logic                    word_ready_o,
  input  logic                    full_i,
  output logic [2:0]              q_o,
  output logic                    pouring_o,
  output logic                    pouring_last_o,
`ifdef SEQ_POURER_CNT_EN
  output logic [LEN_BITS-1:0]     sym_cnt_o,
`endif
  output logic                    busy_o
);

  localparam int unsigned WordW = 2 * WORD_BASES;
  localparam int unsigned LeftW = $clog2(WORD_BASES + 1);

  typedef enum logic [1:0] {StIdle, StPour, StEnd} state_e;

  state_e              state_q, state_d;
  logic [LEN_BITS-1:0] remaining_q, remaining_d;
  logic [LeftW-1:0]    word_left_q, word_left_d;
  logic [WordW-1:0]    word_q, word_d;
  logic [2:0]          q_q, q_d;
  logic                pouring_q, pouring_d;
  logic                last_q, last_d;

  logic                word_acc, fresh, emit;
  logic [WordW-1:0]    cur_word;
  logic [LeftW-1:0]    cur_left;
  logic [LEN_BITS-1:0] rem_after;

  // Bases a newly accepted word contributes; the tail of the final word is dropped.
  function automatic logic [LeftW-1:0] chunk(input logic [LEN_BITS-1:0] rem);
    if (32'(rem) >= WORD_BASES) return LeftW'(WORD_BASES);
    return LeftW'(rem);
  endfunction

  assign seq_ready_o  = rst_n & (state_q == StIdle);
  // Requiring remaining > word_left stops a word of the next sequence being swallowed.
  assign word_ready_o = (state_q == StPour) & (remaining_q > LEN_BITS'(word_left_q)) &
                        ((word_left_q == '0) | ((word_left_q == LeftW'(1)) & ~full_i));

  always_comb begin
    word_acc  = word_valid_i & word_ready_o;
    fresh     = word_acc & (word_left_q == '0);
    // An empty register is bypassed so the first base leaves in the accept cycle.
    cur_word  = fresh ? word_i : word_q;
    cur_left  = fresh ? chunk(remaining_q) : word_left_q;
    emit      = (state_q == StPour) & (cur_left != '0) & ~full_i;
    rem_after = emit ? remaining_q - LEN_BITS'(1) : remaining_q;

    state_d     = state_q;
    remaining_d = remaining_q;
    word_left_d = word_left_q;
    word_d      = word_q;
    q_d         = 3'b000;
    pouring_d   = 1'b0;
    last_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (seq_valid_i) begin
          remaining_d = seq_len_i;
          word_left_d = '0;
          state_d     = (seq_len_i == '0) ? StEnd : StPour;
        end
      end
      StPour: begin
        pouring_d = pouring_q;
        if (remaining_q == '0) begin
          state_d   = StIdle;
          pouring_d = 1'b0;
        end else begin
          remaining_d = rem_after;
          word_d      = cur_word;
          word_left_d = cur_left;
          if (emit) begin
            q_d         = {1'b1, cur_word[1:0]};
            pouring_d   = 1'b1;
            last_d      = (rem_after == '0);
            word_d      = cur_word >> 2;
            word_left_d = cur_left - LeftW'(1);
          end
          if (word_acc && !fresh) begin
            word_d      = word_i;
            word_left_d = chunk(rem_after);
          end
        end
      end
      StEnd: begin
        if (last_q) begin
          state_d = StIdle;
        end else if (!full_i) begin
          last_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      word_left_q <= '0;
      word_q      <= '0;
      q_q         <= 3'b000;
      pouring_q   <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      word_left_q <= word_left_d;
      word_q      <= word_d;
      q_q         <= q_d;
      pouring_q   <= pouring_d;
      last_q      <= last_d;
    end
  end

`ifdef SEQ_POURER_CNT_EN
  logic [LEN_BITS-1:0] sym_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q <= '0;
    end else if ((state_q == StIdle) && seq_valid_i) begin
      sym_cnt_q <= '0;
    end else if (emit) begin
      sym_cnt_q <= sym_cnt_q + LEN_BITS'(1);
    end
  end

  assign sym_cnt_o = sym_cnt_q;
`endif

  assign q_o            = q_q;
  assign pouring_o      = pouring_q;
  assign pouring_last_o = last_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_seq_pourer.sv
// Randomised bench for seq_pourer: a queue-based model of the base stream and pending-base count
// predicts every symbol, stall bubble, word request and framing flag.
module tb_seq_pourer;

  localparam int WB = 16;
  localparam int LB = 10;
  localparam int W  = 2 * WB;

  logic          clk, rst_n;
  logic          seq_valid_i;
  logic [LB-1:0] seq_len_i;
  logic          seq_ready_o;
  logic          word_valid_i;
  logic [W-1:0]  word_i;
  logic          word_ready_o;
  logic          full_i;
  logic [2:0]    q_o;
  logic          pouring_o, pouring_last_o, busy_o;
`ifdef SEQ_POURER_CNT_EN
  logic [LB-1:0] sym_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  seq_pourer #(.WORD_BASES(WB), .LEN_BITS(LB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seq_valid_i   (seq_valid_i),
    .seq_len_i     (seq_len_i),
    .seq_ready_o   (seq_ready_o),
    .word_valid_i  (word_valid_i),
    .word_i        (word_i),
    .word_ready_o  (word_ready_o),
    .full_i        (full_i),
    .q_o           (q_o),
    .pouring_o     (pouring_o),
    .pouring_last_o(pouring_last_o),
`ifdef SEQ_POURER_CNT_EN
    .sym_cnt_o     (sym_cnt_o),
`endif
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_q"}, 32'(q_o), 0);
    check({tag, "_pour"}, 32'(pouring_o), 0);
    check({tag, "_last"}, 32'(pouring_last_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_wrdy"}, 32'(word_ready_o), 0);
`ifdef SEQ_POURER_CNT_EN
    check({tag, "_cnt"}, 32'(sym_cnt_o), 0);
`endif
  endtask

  // One complete sequence; exp_bubbles < 0 skips the stall-cycle count.
  task automatic run_seq(input int len, input int full_pct, input int gap_pct,
                         input int stall_after, input int abort_after,
                         input logic [W-1:0] w0, input bit use_w0, input int exp_bubbles);
    logic [W-1:0] words[$];
    logic [1:0]   exp_q[$];
    logic [W-1:0] w;
    int nwords, wi, si, acc, stall_left, bubbles;
    bit exp_v, exp_rdy, saw_last, done, aborted, stall_done;

    nwords = (len + WB - 1) / WB;
    for (int j = 0; j < nwords; j++) begin
      w = (j == 0 && use_w0) ? w0 : W'($urandom());
      words.push_back(w);
      for (int k = 0; k < WB; k++) if (j * WB + k < len) exp_q.push_back(w[2*k +: 2]);
    end

    @(posedge clk); #1;
    seq_valid_i = 1'b1;
    seq_len_i   = LB'(len);
    full_i      = 1'b0;
    @(negedge clk);
    check("desc_ready", 32'(seq_ready_o), 1);

    wi = 0; si = 0; acc = 0; stall_left = 0; bubbles = 0;
    exp_v = 0; saw_last = 0; done = 0; aborted = 0; stall_done = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(posedge clk); #1;
      seq_valid_i  = 1'b0;
      full_i       = (stall_left > 0) || ($urandom_range(0, 99) < full_pct);
      if (stall_left > 0) stall_left--;
      word_valid_i = (wi < nwords) && ($urandom_range(0, 99) >= gap_pct);
      word_i       = (wi < nwords) ? words[wi] : W'($urandom());
      @(negedge clk);
`ifdef SEQ_POURER_CNT_EN
      if (cyc == 0) check("cnt_cleared", 32'(sym_cnt_o), 0);
`endif
      if (saw_last) begin
        check("end_pour", 32'(pouring_o), 0);
        check("end_q", 32'(q_o), 0);
        check("end_last", 32'(pouring_last_o), 0);
        check("end_seq_ready", 32'(seq_ready_o), 1);
        check("end_busy", 32'(busy_o), 0);
`ifdef SEQ_POURER_CNT_EN
        check("cnt_held", 32'(sym_cnt_o), 32'(len));
`endif
        done = 1;
      end else begin
        check("q_valid", 32'(q_o[2]), 32'(exp_v));
        if (q_o[2]) begin
          if (si < len) check("sym", 32'(q_o[1:0]), 32'(exp_q[si]));
          else check("sym_extra", 32'(si), 32'(len - 1));
          si++;
          check("last_flag", 32'(pouring_last_o), 32'(si == len));
          check("pour_on", 32'(pouring_o), 1);
          if (si == len) begin
            saw_last = 1;
`ifdef SEQ_POURER_CNT_EN
            check("cnt_final", 32'(sym_cnt_o), 32'(len));
`endif
          end
        end else begin
          check("pour_hold", 32'(pouring_o), 32'(si > 0));
          check("no_last", 32'(pouring_last_o), 0);
          if (pouring_o) bubbles++;
        end
        // Pending bases held = accepted minus already shown on q_o.
        exp_rdy = (wi < nwords) && ((acc - si == 0) || ((acc - si == 1) && !full_i));
        check("word_ready", 32'(word_ready_o), 32'(exp_rdy));
        if (word_valid_i && word_ready_o) begin
          acc += (len - wi * WB < WB) ? len - wi * WB : WB;
          wi++;
        end
        exp_v = (acc > si) && !full_i;
        if (stall_after > 0 && si == stall_after && !stall_done) begin
          stall_left = 3;
          stall_done = 1;
        end
        if (abort_after > 0 && si == abort_after) begin
          #3 rst_n = 1'b0;
          #1 check_idle_outputs("async_rst");
          check("async_rst_sready", 32'(seq_ready_o), 0);
          word_valid_i = 1'b0;
          full_i       = 1'b0;
          @(negedge clk);
          rst_n   = 1'b1;
          aborted = 1;
          done    = 1;
        end
      end
    end
    word_valid_i = 1'b0;
    full_i       = 1'b0;
    if (!done) check("timeout", 32'(si), 32'(len));
    if (!aborted) begin
      check("words_used", 32'(wi), 32'(nwords));
      if (exp_bubbles >= 0) check("bubbles", 32'(bubbles), 32'(exp_bubbles));
    end
  endtask

  task automatic run_zero(input int full_cycles);
    int markers;
    bit prev_full, seen, done;
    @(posedge clk); #1;
    seq_valid_i = 1'b1;
    seq_len_i   = '0;
    @(negedge clk);
    check("zero_desc_ready", 32'(seq_ready_o), 1);
    markers = 0; seen = 0; done = 0; prev_full = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      seq_valid_i = 1'b0;
      full_i      = (k < full_cycles);
      @(negedge clk);
      check("zero_wrdy", 32'(word_ready_o), 0);
      check("zero_q", 32'(q_o), 0);
      check("zero_pour", 32'(pouring_o), 0);
      if (seen) begin
        check("zero_after_last", 32'(pouring_last_o), 0);
        check("zero_after_ready", 32'(seq_ready_o), 1);
        check("zero_after_busy", 32'(busy_o), 0);
        done = 1;
      end else if (pouring_last_o) begin
        markers++;
        seen = 1;
        check("zero_marker_not_full", 32'(prev_full), 0);
      end
      prev_full = full_i;
    end
    full_i = 1'b0;
    check("zero_markers", 32'(markers), 1);
    check("zero_done", 32'(done), 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    seq_valid_i  = 1'b0;
    seq_len_i    = '0;
    word_valid_i = 1'b0;
    word_i       = '0;
    full_i       = 1'b0;
    #2 check_idle_outputs("reset");
    check("reset_sready", 32'(seq_ready_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_sready", 32'(seq_ready_o), 1);

    run_seq(5, 0, 0, 0, 0, W'(32'h0000_03E4), 1, 0);
    run_seq(40, 0, 0, 0, 0, '0, 0, 0);
    run_seq(20, 0, 0, 7, 0, '0, 0, 3);
    run_zero(0);
    run_zero(2);
    run_seq(30, 0, 0, 0, 10, '0, 0, -1);
    run_seq(3, 0, 0, 0, 0, '0, 0, 0);
    run_seq(17, 0, 0, 0, 0, '0, 0, 0);
    run_seq(16, 20, 0, 0, 0, '0, 0, -1);
    run_seq(32, 0, 30, 0, 0, '0, 0, -1);
    run_seq(1, 0, 0, 0, 0, '0, 0, 0);
    for (int n = 0; n < 8; n++) run_seq($urandom_range(1, 70), 25, 20, 0, 0, '0, 0, -1);
    run_seq(1023, 10, 10, 0, 0, '0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
